// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath control outputs shared by the
// multicycle RV32I controller (slave) and its datapath (master).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic [1:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic [3:0] ALUControl;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       Illegal;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
        input  IRWrite, PCWrite, RegWrite, MemWrite, Illegal
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
        output IRWrite, PCWrite, RegWrite, MemWrite, Illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory wait states, beq/bne, extended ALU decode and a sticky illegal trap.
module multicycle_controller #(
    parameter int MEM_WAIT = 0,
    parameter bit EXT_ALU  = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_controller_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, ERROR
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state, state_nx;
    logic [3:0] wait_cnt;
    logic       run;
    logic       mem_state, wait_done, taken;
    logic [1:0] alu_op;
    logic       pc_update, branch, ir_write, reg_write, mem_write;

    assign mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign wait_done = !mem_state || (wait_cnt == WAIT_LAST);
    assign taken     = bus.Zero ^ bus.funct3[0];

    // run stays low for the first edge after reset release, so that edge
    // opens FETCH cycle 1 instead of closing it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
            run      <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                state <= state_nx;
                if (state_nx != state)
                    wait_cnt <= '0;
                else if (mem_state && !wait_done)
                    wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:    if (wait_done) state_nx = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_R:         state_nx = EXECUTER;
                    OP_I:         state_nx = EXECUTEI;
                    OP_JAL:       state_nx = JAL;
                    OP_BR:        state_nx = (bus.funct3[2:1] == 2'b00) ? BRANCH : ERROR;
                    default:      state_nx = ERROR;
                endcase
            end
            MEMADR:   state_nx = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (wait_done) state_nx = MEMWB;
            MEMWB:    state_nx = FETCH;
            MEMWRITE: if (wait_done) state_nx = FETCH;
            EXECUTER: state_nx = ALUWB;
            EXECUTEI: state_nx = ALUWB;
            JAL:      state_nx = ALUWB;
            ALUWB:    state_nx = FETCH;
            BRANCH:   state_nx = FETCH;
            ERROR:    state_nx = ERROR;
            default:  state_nx = FETCH;
        endcase
    end

    always_comb begin
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.AdrSrc    = 1'b0;
        alu_op        = 2'b00;
        ir_write      = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        case (state)
            FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                ir_write      = wait_done;
                pc_update     = wait_done;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            MEMREAD:  bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_write     = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mem_write  = 1'b1;
            end
            EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b10;
            end
            EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                alu_op      = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            BRANCH: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b01;
                branch      = 1'b1;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pc_update   = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are masked by run, which reset clears asynchronously.
    assign bus.IRWrite  = ir_write & run;
    assign bus.PCWrite  = (pc_update | (branch & taken)) & run;
    assign bus.RegWrite = reg_write & run;
    assign bus.MemWrite = mem_write & run;
    assign bus.Illegal  = (state == ERROR);

    always_comb begin
        bus.ALUControl = 4'b0000;
        case (alu_op)
            2'b01: bus.ALUControl = 4'b0001;
            2'b10: begin
                case (bus.funct3)
                    3'b000: bus.ALUControl = (bus.op[5] & bus.funct7b5) ? 4'b0001 : 4'b0000;
                    3'b010: bus.ALUControl = 4'b0101;
                    3'b110: bus.ALUControl = 4'b0011;
                    3'b111: bus.ALUControl = 4'b0010;
                    3'b100: if (EXT_ALU) bus.ALUControl = 4'b0100;
                    3'b001: if (EXT_ALU) bus.ALUControl = 4'b0110;
                    3'b101: if (EXT_ALU) bus.ALUControl = bus.funct7b5 ? 4'b1000 : 4'b0111;
                    default: bus.ALUControl = 4'b0000;
                endcase
            end
            default: bus.ALUControl = 4'b0000;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BR:   bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three instances (wait 0/1/2) driven by a
// vector table whose per-cycle expected control words go through a queue.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_controller_if b0 ();
    multicycle_controller_if b1 ();
    multicycle_controller_if b2 ();

    assign b0.op = op;  assign b0.funct3 = funct3;  assign b0.funct7b5 = funct7b5;  assign b0.Zero = zero;
    assign b1.op = op;  assign b1.funct3 = funct3;  assign b1.funct7b5 = funct7b5;  assign b1.Zero = zero;
    assign b2.op = op;  assign b2.funct3 = funct3;  assign b2.funct7b5 = funct7b5;  assign b2.Zero = zero;

    multicycle_controller #(.MEM_WAIT(0), .EXT_ALU(1'b1)) u0 (.clk(clk), .reset(reset), .bus(b0));
    multicycle_controller #(.MEM_WAIT(1), .EXT_ALU(1'b0)) u1 (.clk(clk), .reset(reset), .bus(b1));
    multicycle_controller #(.MEM_WAIT(2), .EXT_ALU(1'b1)) u2 (.clk(clk), .reset(reset), .bus(b2));

    localparam int B_IR = 13, B_PC = 14, B_MW = 16, B_ILL = 17;

    typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_ERR} kind_t;

    typedef struct {
        string      name;
        int         dut;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        kind_t      kind;
        logic [1:0] imm;
        logic [3:0] alu;
        logic       pcw;
        int         cpi;
    } vec_t;

    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;

    exp_t q[$];
    vec_t tbl[$];
    int   waitv[3] = '{0, 1, 2};

    function automatic logic [17:0] mk(input logic [1:0] imm, a, b, r, input logic adr,
                                       input logic [3:0] alu, input logic ir, pc, rw, mw, ill);
        return {ill, mw, rw, pc, ir, alu, adr, r, b, a, imm};
    endfunction

    function automatic logic [17:0] snap(input int sel);
        case (sel)
            0: return mk(b0.ImmSrc, b0.ALUSrcA, b0.ALUSrcB, b0.ResultSrc, b0.AdrSrc, b0.ALUControl,
                         b0.IRWrite, b0.PCWrite, b0.RegWrite, b0.MemWrite, b0.Illegal);
            1: return mk(b1.ImmSrc, b1.ALUSrcA, b1.ALUSrcB, b1.ResultSrc, b1.AdrSrc, b1.ALUControl,
                         b1.IRWrite, b1.PCWrite, b1.RegWrite, b1.MemWrite, b1.Illegal);
            default: return mk(b2.ImmSrc, b2.ALUSrcA, b2.ALUSrcB, b2.ResultSrc, b2.AdrSrc, b2.ALUControl,
                         b2.IRWrite, b2.PCWrite, b2.RegWrite, b2.MemWrite, b2.Illegal);
        endcase
    endfunction

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input logic [17:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    // Expected control word for every cycle of one instruction, plus the first
    // cycle of the following fetch.
    task automatic build(input vec_t v, input int w);
        logic [1:0] i;
        i = v.imm;
        repeat (w) push("fetch_wait", mk(i, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 0, 0, 0, 0, 0));
        push("fetch", mk(i, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 1, 1, 0, 0, 0));
        push("decode", mk(i, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0, 0, 0, 0, 0, 0));
        case (v.kind)
            K_R, K_I: begin
                push("exec", mk(i, 2'd2, (v.kind == K_I) ? 2'd1 : 2'd0, 2'd0, 1'b0, v.alu, 0, 0, 0, 0, 0));
                push("aluwb", mk(i, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 0, 0, 1, 0, 0));
            end
            K_LW: begin
                push("memadr", mk(i, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0, 0, 0, 0, 0, 0));
                repeat (w + 1) push("memread", mk(i, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 0, 0, 0, 0, 0));
                push("memwb", mk(i, 2'd0, 2'd0, 2'd1, 1'b0, 4'd0, 0, 0, 1, 0, 0));
            end
            K_SW: begin
                push("memadr", mk(i, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0, 0, 0, 0, 0, 0));
                repeat (w + 1) push("memwrite", mk(i, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 0, 0, 0, 1, 0));
            end
            K_BR:  push("branch", mk(i, 2'd2, 2'd0, 2'd0, 1'b0, 4'd1, 0, v.pcw, 0, 0, 0));
            K_JAL: begin
                push("jal", mk(i, 2'd1, 2'd2, 2'd0, 1'b0, 4'd0, 0, 1, 0, 0, 0));
                push("aluwb", mk(i, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 0, 0, 1, 0, 0));
            end
            default: repeat (12) push("error", mk(i, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 0, 0, 0, 0, 1));
        endcase
        if (v.kind != K_ERR)
            push("next_fetch", mk(i, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, (w == 0), (w == 0), 0, 0, 0));
    endtask

    task automatic run_vec(input vec_t v);
        int w, n, ir_seen, ir_first, ir_second;
        logic [17:0] s;
        exp_t e;
        w = waitv[v.dut];
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.zero;
        @(negedge clk);
        check({v.name, ":reset"}, snap(v.dut), mk(v.imm, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        build(v, w);
        n = 0; ir_seen = 0; ir_first = 0; ir_second = 0;
        while ((q.size() > 0 || (v.kind != K_ERR && ir_seen < 2)) && n < 60) begin
            @(negedge clk);
            n++;
            s = snap(v.dut);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({v.name, ":", e.tag}, s, e.v);
            end
            if (s[B_IR]) begin
                ir_seen++;
                if (ir_seen == 1) ir_first = n;
                else if (ir_seen == 2) ir_second = n;
            end
        end
        if (v.kind != K_ERR)
            check_int({v.name, ":cpi"}, ir_second - ir_first, v.cpi);
    endtask

    initial begin
        //                name      dut op          f3      f7    zero  kind   imm    alu      pcw   cpi
        tbl.push_back('{"add",     0, 7'b0110011, 3'b000, 1'b0, 1'b0, K_R,   2'b00, 4'b0000, 1'b0, 4});
        tbl.push_back('{"sub",     0, 7'b0110011, 3'b000, 1'b1, 1'b0, K_R,   2'b00, 4'b0001, 1'b0, 4});
        tbl.push_back('{"or",      0, 7'b0110011, 3'b110, 1'b0, 1'b0, K_R,   2'b00, 4'b0011, 1'b0, 4});
        tbl.push_back('{"and",     0, 7'b0110011, 3'b111, 1'b0, 1'b0, K_R,   2'b00, 4'b0010, 1'b0, 4});
        tbl.push_back('{"slt",     0, 7'b0110011, 3'b010, 1'b0, 1'b0, K_R,   2'b00, 4'b0101, 1'b0, 4});
        tbl.push_back('{"sll",     0, 7'b0110011, 3'b001, 1'b0, 1'b0, K_R,   2'b00, 4'b0110, 1'b0, 4});
        tbl.push_back('{"sltu",    0, 7'b0110011, 3'b011, 1'b0, 1'b0, K_R,   2'b00, 4'b0000, 1'b0, 4});
        tbl.push_back('{"addi_b30",0, 7'b0010011, 3'b000, 1'b1, 1'b0, K_I,   2'b00, 4'b0000, 1'b0, 4});
        tbl.push_back('{"srai",    0, 7'b0010011, 3'b101, 1'b1, 1'b0, K_I,   2'b00, 4'b1000, 1'b0, 4});
        tbl.push_back('{"xori_e1", 0, 7'b0010011, 3'b100, 1'b0, 1'b0, K_I,   2'b00, 4'b0100, 1'b0, 4});
        tbl.push_back('{"srli_w2", 2, 7'b0010011, 3'b101, 1'b0, 1'b0, K_I,   2'b00, 4'b0111, 1'b0, 6});
        tbl.push_back('{"xori_e0", 1, 7'b0010011, 3'b100, 1'b0, 1'b0, K_I,   2'b00, 4'b0000, 1'b0, 5});
        tbl.push_back('{"sll_e0",  1, 7'b0110011, 3'b001, 1'b0, 1'b0, K_R,   2'b00, 4'b0000, 1'b0, 5});
        tbl.push_back('{"lw_w2",   2, 7'b0000011, 3'b010, 1'b0, 1'b0, K_LW,  2'b00, 4'b0000, 1'b0, 9});
        tbl.push_back('{"lw_w0",   0, 7'b0000011, 3'b010, 1'b0, 1'b0, K_LW,  2'b00, 4'b0000, 1'b0, 5});
        tbl.push_back('{"sw_w1",   1, 7'b0100011, 3'b010, 1'b0, 1'b0, K_SW,  2'b01, 4'b0000, 1'b0, 6});
        tbl.push_back('{"beq_z1",  0, 7'b1100011, 3'b000, 1'b0, 1'b1, K_BR,  2'b10, 4'b0001, 1'b1, 3});
        tbl.push_back('{"bne_z1",  0, 7'b1100011, 3'b001, 1'b0, 1'b1, K_BR,  2'b10, 4'b0001, 1'b0, 3});
        tbl.push_back('{"bne_z0",  0, 7'b1100011, 3'b001, 1'b0, 1'b0, K_BR,  2'b10, 4'b0001, 1'b1, 3});
        tbl.push_back('{"beq_z0w2",2, 7'b1100011, 3'b000, 1'b0, 1'b0, K_BR,  2'b10, 4'b0001, 1'b0, 5});
        tbl.push_back('{"jal_w2",  2, 7'b1101111, 3'b000, 1'b0, 1'b0, K_JAL, 2'b11, 4'b0000, 1'b0, 6});
        tbl.push_back('{"blt_ill", 0, 7'b1100011, 3'b100, 1'b0, 1'b0, K_ERR, 2'b10, 4'b0000, 1'b0, 0});
        tbl.push_back('{"op7f_ill",0, 7'b1111111, 3'b000, 1'b0, 1'b0, K_ERR, 2'b00, 4'b0000, 1'b0, 0});

        #1 reset = 1'b1;
        foreach (tbl[k]) run_vec(tbl[k]);

        // Sticky trap from the last vector: async reset clears Illegal, then a clean fetch.
        #2 reset = 1'b1;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        #1 check("trap_reset", snap(0), mk(2'b00, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("trap_refetch", snap(0), mk(2'b00, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 1, 1, 0, 0, 0));

        // Async reset in the middle of a wait-stretched MEMWRITE.
        @(negedge clk);
        reset = 1'b1;
        op = 7'b0100011; funct3 = 3'b010;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("mw_before", {17'd0, snap(2)[B_MW]}, 18'd1);
        #2 reset = 1'b1;
        #1 check("mw_async_drop", snap(2), mk(2'b01, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mw_refetch1", snap(2), mk(2'b01, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        check("mw_refetch3", snap(2), mk(2'b01, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 1, 1, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I datapath. It replaces the single-cycle main/ALU decoder pair with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It adds a parametrised memory wait-state count, `bne` support, an extended ALU-operation decode and a sticky illegal-instruction trap. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- `MEM_WAIT`, default 0: extra wait cycles inserted in every memory-access state (FETCH, MEMREAD, MEMWRITE); legal range 0..15.
- `EXT_ALU`, default 1: when 1, decodes xor/sll/srl/sra; when 0, those funct3 values decode to add.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `op` input 7: instruction opcode from the instruction register.
- `funct3` input 3: instruction funct3.
- `funct7b5` input 1: instruction bit 30.
- `Zero` input 1: ALU zero flag.
- `ImmSrc` output 2: immediate format (00 I, 01 S, 10 B, 11 J).
- `ALUSrcA` output 2: 00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB` output 2: 00 rs2, 01 Imm, 10 constant 4.
- `ResultSrc` output 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `AdrSrc` output 1: 0 PC, 1 Result.
- `ALUControl` output 4: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` output 1 each: register and memory write enables.
- `Illegal` output 1: high while in the ERROR state.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, ERROR.
- Transitions:
  - FETCH → DECODE.
  - DECODE branches on `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1101111 → JAL.
    - 1100011 with funct3 000 or 001 → BRANCH.
    - Anything else → ERROR.
  - MEMADR: lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER and EXECUTEI → ALUWB → FETCH.
  - JAL → ALUWB.
  - BRANCH → FETCH.
  - ERROR holds until reset.
- Per-state outputs. Unlisted outputs are 0. ALUOp is internal.
  - FETCH: AdrSrc 0, IRWrite, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00.
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite.
  - BRANCH: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate.
- PC write and branch condition:
  - PCWrite = PCUpdate | (Branch & taken).
  - taken = Zero XOR funct3[0]: beq is taken when Zero = 1, bne when Zero = 0.
- ImmSrc is combinational from `op` in every state:
  - lw and I-type → 00.
  - sw → 01.
  - branch → 10.
  - jal → 11.
  - otherwise → 00.
- ALU decode:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10 decodes by funct3:
    - 000 → sub if op[5] & funct7b5, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - 100 → xor.
    - 001 → sll.
    - 101 → sra if funct7b5, else srl.
  - With EXT_ALU = 0, funct3 values 100, 001 and 101 give add.
  - funct3 011 gives add.

## Timing
- Moore outputs, except that PCWrite depends combinationally on `Zero` in BRANCH.
- Wait counter:
  - In FETCH, MEMREAD and MEMWRITE the FSM stays MEM_WAIT+1 cycles; a 4-bit counter loads 0 on state entry.
  - IRWrite and the FETCH PCUpdate are asserted only on the final FETCH cycle.
  - MemWrite is asserted on every MEMWRITE cycle.
  - Mux selects are held steady throughout the wait.
- Cycles per instruction at MEM_WAIT = W:
  - lw: 5 + 2W.
  - sw: 4 + 2W.
  - R-type and I-type ALU: 4 + W.
  - jal: 4 + W.
  - branch: 3 + W.
- Reset behaviour:
  - While `reset` is high: state is FETCH, counter is 0, and IRWrite, PCWrite, RegWrite, MemWrite and Illegal are 0.
  - Mux outputs take their FETCH values: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, ALUControl 0000.
  - Reset asserted mid-instruction aborts it immediately; no write enable is asserted afterwards until the next FETCH completes.
- The first rising edge after reset deasserts begins FETCH cycle 1.

## Test plan
- MEM_WAIT 0, `add` (op 0110011, funct3 000, funct7b5 0):
  - Sequence FETCH, DECODE, EXECUTER, ALUWB, then FETCH.
  - ALUControl 0000 in EXECUTER; RegWrite 1 only in ALUWB.
  - Repeat with funct7b5 1: ALUControl 0001.
- MEM_WAIT 2, `lw`:
  - FETCH lasts 3 cycles, IRWrite/PCWrite pulse on the 3rd only.
  - MEMREAD lasts 3 cycles with AdrSrc 1; total 9 cycles; RegWrite in MEMWB.
- `beq` with Zero 1 → PCWrite 1 in BRANCH. `bne` (funct3 001) with Zero 1 → PCWrite 0. `bne` with Zero 0 → PCWrite 1.
- `sw` at MEM_WAIT 1:
  - MemWrite high for exactly 2 cycles; ImmSrc 01.
  - Total 6 cycles; RegWrite never asserted.
- Illegal input:
  - Opcode 1111111 → ERROR after DECODE; Illegal stays 1 for 10+ cycles; all enables 0.
  - Reset returns the FSM to FETCH with Illegal 0.
- Reset asserted asynchronously mid-MEMWRITE → MemWrite drops to 0 without waiting for a clock edge; state is FETCH on release.
- EXT_ALU 0: `xori` (funct3 100) → ALUControl 0000. EXT_ALU 1: `srai` → 1000.
